// File: rtl/hazard_unit.sv
// Pipeline hazard controller for a 5-stage in-order core.
// Decodes stage-register enables and bubble/flush controls from the current
// FSM state and the hazard inputs. It also keeps a registered halt flag and a
// saturating counter of front-end stall cycles.
module hazard_unit #(
  parameter int LU_STALL_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_dREN,
  input  logic             exmem_dWEN,
  input  logic             idex_dREN,
  input  logic [4:0]       idex_wsel,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             memwb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDUSE   = 2'd1,
    MEMWAIT = 2'd2,
    HALTED  = 2'd3
  } state_t;

  // One bit per pipeline control, kept together so each hazard case is one assignment.
  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
    logic ifid_fl;
    logic idex_fl;
  } ctl_t;

  localparam ctl_t CTL_NONE  = '0;
  localparam ctl_t CTL_ALL   = '{pc: 1'b1, ifid: 1'b1, idex: 1'b1, exmem: 1'b1,
                                 memwb: 1'b1, ifid_fl: 1'b0, idex_fl: 1'b0};
  // Hold PC and IF/ID and push a bubble into ID/EX. The back stages keep draining.
  localparam ctl_t CTL_STALL = '{pc: 1'b0, ifid: 1'b0, idex: 1'b1, exmem: 1'b1,
                                 memwb: 1'b1, ifid_fl: 1'b0, idex_fl: 1'b1};
  // Redirect: take the new PC and squash the two wrong-path instructions.
  localparam ctl_t CTL_REDIR = '{pc: 1'b1, ifid: 1'b1, idex: 1'b1, exmem: 1'b1,
                                 memwb: 1'b1, ifid_fl: 1'b1, idex_fl: 1'b1};
  localparam logic [1:0] LU_LOAD = 2'(LU_STALL_CYCLES - 1);

  state_t           r_state;
  logic [1:0]       r_bub_cnt;
  logic             r_resume_lu;
  logic             r_halt;
  logic [CNT_W-1:0] r_stall_cnt;

  state_t     w_next_state;
  logic [1:0] w_bub_cnt_next;
  logic       w_resume_next;
  logic       w_use_run;
  ctl_t       w_ctl;
  logic       w_mem_wait;
  logic       w_load_use;
  logic       w_ctrl_xfer;

  assign w_mem_wait  = (exmem_dREN | exmem_dWEN) & ~dhit;
  assign w_load_use  = idex_dREN && (idex_wsel != 5'd0) &&
                       ((idex_wsel == ifid_rs) || (idex_wsel == ifid_rt));
  assign w_ctrl_xfer = branch_taken | jump;

  // Next-state and Mealy control decode.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave one unassigned and infer a latch.
    w_ctl          = CTL_NONE;
    w_next_state   = r_state;
    w_bub_cnt_next = r_bub_cnt;
    w_resume_next  = r_resume_lu;
    w_use_run      = 1'b0;

    unique case (r_state)
      RUN: begin
        if (memwb_halt) begin
          w_next_state = HALTED;
        end else if (w_mem_wait) begin
          w_next_state  = MEMWAIT;
          w_resume_next = 1'b0;
        end else begin
          w_use_run = 1'b1;
        end
      end
      LDUSE: begin
        if (memwb_halt) begin
          w_next_state = HALTED;
        end else if (w_mem_wait) begin
          // Park the bubble count and come back to LDUSE once memory answers.
          w_next_state  = MEMWAIT;
          w_resume_next = 1'b1;
        end else begin
          w_ctl          = CTL_STALL;
          w_bub_cnt_next = (r_bub_cnt != 2'd0) ? r_bub_cnt - 2'd1 : 2'd0;
          w_next_state   = (r_bub_cnt <= 2'd1) ? RUN : LDUSE;
        end
      end
      MEMWAIT: begin
        if (memwb_halt) begin
          w_next_state = HALTED;
        end else if (dhit) begin
          if (r_resume_lu) begin
            w_ctl         = CTL_STALL;
            w_next_state  = LDUSE;
            w_resume_next = 1'b0;
          end else begin
            w_use_run = 1'b1;
          end
        end
      end
      HALTED: ;
      default: w_next_state = RUN;
    endcase

    // Front-end rules shared by RUN and the MEMWAIT release cycle.
    if (w_use_run) begin
      w_next_state = RUN;
      if (w_load_use) begin
        w_ctl          = CTL_STALL;
        w_bub_cnt_next = LU_LOAD;
        w_next_state   = (LU_STALL_CYCLES > 1) ? LDUSE : RUN;
      end else if (w_ctrl_xfer) begin
        w_ctl = CTL_REDIR;
      end else if (!ihit) begin
        w_ctl = CTL_STALL;
      end else begin
        w_ctl = CTL_ALL;
      end
    end
  end

  // Controls are forced low while reset is held, independent of the clock.
  assign pc_en      = w_ctl.pc      & nRST;
  assign ifid_en    = w_ctl.ifid    & nRST;
  assign idex_en    = w_ctl.idex    & nRST;
  assign exmem_en   = w_ctl.exmem   & nRST;
  assign memwb_en   = w_ctl.memwb   & nRST;
  assign ifid_flush = w_ctl.ifid_fl & nRST;
  assign idex_flush = w_ctl.idex_fl & nRST;

  // State, bubble counter, halt flag and saturating stall counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= RUN;
      r_bub_cnt   <= 2'd0;
      r_resume_lu <= 1'b0;
      r_halt      <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      // NOTE: non-blocking updates, so every register samples the pre-edge values.
      r_state     <= w_next_state;
      r_bub_cnt   <= w_bub_cnt_next;
      r_resume_lu <= w_resume_next;
      r_halt      <= (w_next_state == HALTED);
      if (!w_ctl.pc && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign halt      = r_halt;
  assign stall_cnt = r_stall_cnt;
  assign state     = r_state;

endmodule
